// File: rtl/brq_pkg.sv
// rtl/brq_pkg.sv - shared constants and types for the branch resolve queue
package brq_pkg;

   localparam int BRQ_DEPTH_DEFAULT = 4;
   localparam int BRQ_STAT_W        = 16;

   typedef logic [BRQ_STAT_W-1:0] brq_stat_t;

endpackage

// File: rtl/brq_ring.sv
// rtl/brq_ring.sv - circular buffer of 1-bit predictions with push/pop/flush
import brq_pkg::*;

module brq_ring #(
   parameter int DEPTH = BRQ_DEPTH_DEFAULT,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             push_data,
   input  logic             pop,
   output logic             pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign full     = (cnt_q == CNT_W'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign count    = cnt_q;
   assign pop_data = mem_q[rptr_q];

   // Next-state: flush wins; pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push) begin
            mem_d[wptr_q] = push_data;
            wptr_d        = wptr_q + 1'b1;
         end
         if (pop) begin
            rptr_d = rptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Storage, pointers and count registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order prediction tracker driving predictor training; BRQ_STATS_EN builds statistics counters
import brq_pkg::*;

module branch_resolve_queue #(
   parameter int DEPTH = BRQ_DEPTH_DEFAULT,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             pred_valid,
   input  logic             pred_taken,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   output logic             upd_result,
   output logic             upd_taken,
   output logic             mispredict,
   output logic [CNT_W-1:0] occupancy,
   output logic             underflow_err,
   output brq_stat_t        stat_total,
   output brq_stat_t        stat_miss
);

   logic full, empty, entry;
   logic push, pop, miss;
   logic upd_result_q, upd_result_d;
   logic upd_taken_q, upd_taken_d;
   logic mispredict_q, mispredict_d;
   logic underflow_q, underflow_d;

   // A full queue refuses a push even when a pop frees a slot this cycle;
   // an empty queue cannot pop even when a push lands this cycle.
   assign push = pred_valid && !full && !flush;
   assign pop  = res_valid && !empty && !flush;
   assign miss = pop && (entry != res_taken);

   brq_ring #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .push      (push),
      .push_data (pred_taken),
      .pop       (pop),
      .pop_data  (entry),
      .full      (full),
      .empty     (empty),
      .count     (occupancy)
   );

   assign pred_ready    = !full;
   assign upd_result    = upd_result_q;
   assign upd_taken     = upd_taken_q;
   assign mispredict    = mispredict_q;
   assign underflow_err = underflow_q;

   // Update pulse, direction and sticky underflow next-state
   always_comb begin
      upd_result_d = pop;
      upd_taken_d  = pop && res_taken;
      mispredict_d = miss;
      underflow_d  = underflow_q;
      if (flush) begin
         underflow_d = 1'b0;
      end else if (res_valid && empty) begin
         underflow_d = 1'b1;
      end
   end

   // Registered training outputs and error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_result_q <= 1'b0;
         upd_taken_q  <= 1'b0;
         mispredict_q <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         upd_result_q <= upd_result_d;
         upd_taken_q  <= upd_taken_d;
         mispredict_q <= mispredict_d;
         underflow_q  <= underflow_d;
      end
   end

`ifdef BRQ_STATS_EN
   brq_stat_t total_q, total_d;
   brq_stat_t miss_q, miss_d;

   // Saturating counters; flush leaves them alone, only reset clears them
   always_comb begin
      total_d = total_q;
      miss_d  = miss_q;
      if (pop && (total_q != '1)) begin
         total_d = total_q + 1'b1;
      end
      if (miss && (miss_q != '1)) begin
         miss_d = miss_q + 1'b1;
      end
   end

   // Statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_q <= '0;
         miss_q  <= '0;
      end else begin
         total_q <= total_d;
         miss_q  <= miss_d;
      end
   end

   assign stat_total = total_q;
   assign stat_miss  = miss_q;
`else
   assign stat_total = '0;
   assign stat_miss  = '0;
`endif

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks in-flight branch predictions between prediction and resolution. Each prediction issued by the 2-bit saturating-counter predictor is pushed in order. When the execute stage reports the actual outcome, the oldest entry is popped and compared, a mispredict is flagged, and the predictor's `result`/`taken` update pulse is generated. The block sits directly downstream of the predictor's `prediction` output and drives its training inputs.

## Interface
- `DEPTH`, 4: number of outstanding predictions held; power of two, 2..16.
- `CNT_W`, $clog2(DEPTH)+1: occupancy width.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `flush` in 1: discard all outstanding entries (pipeline redirect).
- `pred_valid` in 1: predictor issued a prediction this cycle.
- `pred_taken` in 1: predicted direction.
- `pred_ready` out 1: queue can accept a push (not full).
- `res_valid` in 1: actual outcome of oldest branch available.
- `res_taken` in 1: actual direction.
- `upd_result` out 1: training strobe to predictor `result`.
- `upd_taken` out 1: training direction to predictor `taken`.
- `mispredict` out 1: one-cycle pulse, popped prediction ≠ actual.
- `occupancy` out CNT_W: current entry count.
- `underflow_err` out 1: sticky; resolution arrived with empty queue.
- `stat_total` out 16: resolved-branch count (see Configuration).
- `stat_miss` out 16: mispredict count (see Configuration).

## Operation
- Storage is a circular buffer of `DEPTH` 1-bit entries with a write pointer, a read pointer, and a `CNT_W`-bit count. Pointers wrap modulo `DEPTH`.
- `pred_ready` = (count != DEPTH). It is combinational from the registered count.
- Push: when `pred_valid && pred_ready`, write `pred_taken` at wptr and increment wptr. `pred_valid` while full is dropped and has no effect.
- Pop: when `res_valid` and count != 0, read the entry at rptr and increment rptr. Next cycle: `upd_result`=1, `upd_taken`=`res_taken`, and `mispredict`=(entry != `res_taken`).
- Simultaneous push and pop: both take effect and count is unchanged.
  - When full, the push is refused even if a pop occurs in the same cycle.
  - When empty, the pop is an underflow even if a push occurs in the same cycle. The push still succeeds.
- Underflow: `res_valid` with count==0 sets `underflow_err`. No update pulse is generated and no pointer moves.
- `flush` has priority over same-cycle push and pop. Its effects:
  - count=0, rptr=wptr=0.
  - `underflow_err` cleared.
  - No update pulse.
  - Statistics are not cleared.
- Reset values of outputs:
  - `upd_result`, `upd_taken`, `mispredict`, `underflow_err` = 0.
  - `occupancy` = 0.
  - `pred_ready` = 1.
  - `stat_*` = 0.

## Timing
- Push to visible `occupancy`: 1 cycle.
- Resolution to `upd_result`/`mispredict`: exactly 1 cycle, registered. At most one update per cycle.
- `upd_result` and `mispredict` are single-cycle pulses. Back-to-back resolutions give back-to-back pulses.
- Asserting `rst_n` low mid-operation clears all state immediately, asynchronously. A pending update pulse is lost.

## Configuration
- `BRQ_STATS_EN` defined:
  - `stat_total` increments on every valid pop.
  - `stat_miss` increments on every mispredict.
  - Both saturate at 16'hFFFF and reset only by `rst_n`.
- Not defined: counters are not built, and `stat_total`/`stat_miss` are tied to 0. Ports remain present.

## Structure
- Package `brq_pkg` holds:
  - `BRQ_DEPTH_DEFAULT`.
  - `BRQ_STAT_W` = 16.
  - `typedef logic [BRQ_STAT_W-1:0] brq_stat_t`.
- Sub-module `brq_ring` holds the entry storage, pointers, and count, and provides push/pop/flush and full/empty. The top level holds the compare, update registers, error flag, and statistics.

## Test plan
- Reset, then push T,N,T (DEPTH=4) → `occupancy`=3, `pred_ready`=1. Resolve T,T,T → `upd_result` pulses on 3 consecutive cycles, `mispredict` only on the 2nd.
- Push 4 entries, then push a 5th (N) → dropped, `pred_ready`=0. Resolve ×4 → the 5th entry never appears and `occupancy`=0.
- Full queue, same-cycle push+pop → push refused, `occupancy`=3. Half-full same-cycle push+pop → `occupancy` unchanged, FIFO order preserved across pointer wrap (≥10 cycles).
- `res_valid` on empty queue → `underflow_err`=1 (sticky), no `upd_result`. Then `flush` → `underflow_err`=0.
- `flush` concurrent with push and pop at `occupancy`=2 → `occupancy`=0 next cycle, no update pulse. With `BRQ_STATS_EN`, `stat_total` unchanged.
- `BRQ_STATS_EN`: 5 resolutions with 2 mispredicts → `stat_total`=5, `stat_miss`=2. Force saturation → holds 16'hFFFF. Assert `rst_n` low mid-run → all outputs return to reset values asynchronously.
